// File: rtl/div_if.sv
// Begin/end handshake bundle shared between the execute stage and the divider.
// The execute stage is the master; the divider is the slave.
interface div_if #(
    parameter int WIDTH = 32
);
    logic             div_begin;
    logic [WIDTH-1:0] div_op1;
    logic [WIDTH-1:0] div_op2;
    logic             div_sign;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_busy;
    logic             div_end;

    modport master (
        output div_begin, div_op1, div_op2, div_sign,
        input  quotient, remainder, div_busy, div_end
    );

    modport slave (
        input  div_begin, div_op1, div_op2, div_sign,
        output quotient, remainder, div_busy, div_end
    );
endinterface

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// Signed operands are divided as magnitudes and the signs are re-applied in FIX.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state;
    logic             begin_d;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] op1_raw;
    logic [WIDTH-1:0] dvd_shift;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] quo;
    logic             div_zero;
    logic             q_neg;
    logic             r_neg;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             busy_r;
    logic             end_r;

    logic             start;
    logic [WIDTH-1:0] op1_mag;
    logic [WIDTH-1:0] op2_mag;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic             fits;

    // The trial subtraction is one bit wider than the operands; its top bit is the
    // borrow, so a clear borrow means the divisor fits (covers |op2| = 2^(W-1)).
    always_comb begin
        start     = bus.div_begin & ~begin_d;
        op1_mag   = (bus.div_sign && bus.div_op1[WIDTH-1]) ? -bus.div_op1 : bus.div_op1;
        op2_mag   = (bus.div_sign && bus.div_op2[WIDTH-1]) ? -bus.div_op2 : bus.div_op2;
        rem_shift = {part_rem, dvd_shift[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, divisor_mag};
        fits      = ~rem_diff[WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            begin_d     <= 1'b0;
            counter     <= '0;
            op1_raw     <= '0;
            dvd_shift   <= '0;
            divisor_mag <= '0;
            part_rem    <= '0;
            quo         <= '0;
            div_zero    <= 1'b0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            busy_r      <= 1'b0;
            end_r       <= 1'b0;
        end else begin
            begin_d <= bus.div_begin;
            end_r   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op1_raw     <= bus.div_op1;
                        dvd_shift   <= op1_mag;
                        divisor_mag <= op2_mag;
                        div_zero    <= (bus.div_op2 == '0);
                        q_neg       <= bus.div_sign & (bus.div_op1[WIDTH-1] ^ bus.div_op2[WIDTH-1]);
                        r_neg       <= bus.div_sign & bus.div_op1[WIDTH-1];
                        part_rem    <= '0;
                        quo         <= '0;
                        counter     <= '0;
                        busy_r      <= 1'b1;
                        state       <= CALC;
                    end
                end
                CALC: begin
                    part_rem  <= fits ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                    quo       <= {quo[WIDTH-2:0], fits};
                    dvd_shift <= {dvd_shift[WIDTH-2:0], 1'b0};
                    if (counter == LAST) begin
                        state <= FIX;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                FIX: begin
                    // Divide by zero reports all-ones and hands back the raw dividend.
                    if (div_zero) begin
                        quotient_r  <= '1;
                        remainder_r <= op1_raw;
                    end else begin
                        quotient_r  <= q_neg ? -quo : quo;
                        remainder_r <= r_neg ? -part_rem : part_rem;
                    end
                    busy_r <= 1'b0;
                    state  <= DONE;
                end
                DONE: begin
                    end_r <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.div_busy  = busy_r;
    assign bus.div_end   = end_r;
endmodule

// File: tb/tb_divider.sv
// Directed and lightly randomised checks of the divider: arithmetic via a
// reference model scoreboard, latency, handshake corner cases and async reset.
module tb_divider;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_if #(.WIDTH(W)) bus ();

    divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   errors    = 0;
    int   end_count = 0;

    task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Returns at the falling edge after the start edge; operands are scrambled then.
    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit hold);
        exp_t e;
        model(a, b, s, e.q, e.r);
        @(negedge clk);
        bus.div_op1   = a;
        bus.div_op2   = b;
        bus.div_sign  = s;
        bus.div_begin = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.div_begin = 1'b0;
        bus.div_op1  = $urandom;
        bus.div_op2  = $urandom;
        bus.div_sign = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input string tag, output int cycles);
        bit got = 1'b0;
        cycles = 0;
        while (!got && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            got = bus.div_end;
        end
        checks++;
        assert (got) else begin
            errors++;
            $error("FAIL %s_timeout: observed=no div_end expected=div_end within 100 cycles", tag);
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int c;
        apply_stimulus(a, b, s, 1'b0);
        wait_done(tag, c);
        check_output({tag, "_latency"}, W'(c), 32'd34);
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.div_end === 1'b1) begin
            exp_t e;
            end_count++;
            check_output("busy_at_end", {31'b0, bus.div_busy}, 32'd0);
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_end: observed=div_end expected=no pending operation");
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_output("sb_quotient", bus.quotient, e.q);
                check_output("sb_remainder", bus.remainder, e.r);
            end
        end
    end

    initial begin
        int c;
        int c0;
        rst           = 1'b1;
        bus.div_begin = 1'b0;
        bus.div_op1   = '0;
        bus.div_op2   = '0;
        bus.div_sign  = 1'b0;
        $display("[TB] divider bench start");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_quotient", bus.quotient, 32'd0);
        check_output("reset_remainder", bus.remainder, 32'd0);
        check_output("reset_busy", {31'b0, bus.div_busy}, 32'd0);
        check_output("reset_end", {31'b0, bus.div_end}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        apply_stimulus(32'd100, 32'd7, 1'b0, 1'b0);
        check_output("busy_in_calc", {31'b0, bus.div_busy}, 32'd1);
        wait_done("u100_7", c);
        check_output("u100_7_latency", W'(c), 32'd34);
        check_output("u100_7_q", bus.quotient, 32'd14);
        check_output("u100_7_r", bus.remainder, 32'd2);

        run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        check_output("s_m7_2_q", bus.quotient, 32'hFFFF_FFFD);
        check_output("s_m7_2_r", bus.remainder, 32'hFFFF_FFFF);
        run_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
        check_output("s_7_m2_q", bus.quotient, 32'hFFFF_FFFD);
        check_output("s_7_m2_r", bus.remainder, 32'd1);

        run_op("u_div0", 32'h1234_5678, 32'd0, 1'b0);
        check_output("u_div0_q", bus.quotient, 32'hFFFF_FFFF);
        check_output("u_div0_r", bus.remainder, 32'h1234_5678);
        run_op("s_div0", 32'h1234_5678, 32'd0, 1'b1);
        check_output("s_div0_q", bus.quotient, 32'hFFFF_FFFF);
        check_output("s_div0_r", bus.remainder, 32'h1234_5678);

        run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        check_output("s_ovf_q", bus.quotient, 32'h8000_0000);
        check_output("s_ovf_r", bus.remainder, 32'd0);
        run_op("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_output("u_ovf_q", bus.quotient, 32'd0);
        check_output("u_ovf_r", bus.remainder, 32'h8000_0000);

        run_op("u_maxdiv", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        run_op("s_mindiv", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("s_negmin", 32'h8000_0000, 32'h8000_0000, 1'b1);

        for (int i = 0; i < 6; i++) begin
            run_op("rand", W'($urandom), W'($urandom) >> $urandom_range(0, 28), 1'($urandom_range(0, 1)));
        end

        // div_begin held high through two operation lengths
        c0 = end_count;
        apply_stimulus(32'd1000, 32'd10, 1'b0, 1'b1);
        wait_done("held", c);
        repeat (45) @(posedge clk);
        check_output("held_single_end", W'(end_count - c0), 32'd1);
        @(negedge clk);
        bus.div_begin = 1'b0;
        repeat (2) @(posedge clk);

        // second rising edge during CALC is ignored
        c0 = end_count;
        apply_stimulus(32'd500, 32'd3, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        bus.div_begin = 1'b1;
        @(negedge clk);
        bus.div_begin = 1'b0;
        wait_done("calc_edge", c);
        check_output("calc_edge_latency", W'(c), 32'd30);
        repeat (45) @(posedge clk);
        check_output("calc_edge_single_end", W'(end_count - c0), 32'd1);

        // back-to-back: new edge in the IDLE cycle right after DONE
        c0 = end_count;
        apply_stimulus(32'd1234, 32'd5, 1'b0, 1'b0);
        wait_done("b2b_first", c);
        run_op("b2b_second", 32'hFFFF_FC19, 32'd9, 1'b1);
        check_output("b2b_second_q", bus.quotient, 32'hFFFF_FF91);
        check_output("b2b_ends", W'(end_count - c0), 32'd2);

        // asynchronous reset at counter = 10
        apply_stimulus(32'hFFFF_0000, 32'd3, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_output("abort_quotient", bus.quotient, 32'd0);
        check_output("abort_remainder", bus.remainder, 32'd0);
        check_output("abort_busy", {31'b0, bus.div_busy}, 32'd0);
        check_output("abort_end", {31'b0, bus.div_end}, 32'd0);
        sb.delete();
        c0 = end_count;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (45) @(posedge clk);
        check_output("abort_no_end", W'(end_count - c0), 32'd0);
        run_op("after_reset", 32'hFFFF_0000, 32'd3, 1'b0);
        check_output("after_reset_q", bus.quotient, 32'h5555_0000);
        check_output("after_reset_r", bus.remainder, 32'd0);

        repeat (3) @(posedge clk);
        check_output("sb_drained", W'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
